scroll_sequencer: RTL
=====================

Name: scroll_sequencer

Overview:
- Per-frame scroll register sequencer for one or more tilemap layer controllers (CUS42-style register bus: 3-bit address, 8-bit data, per-layer latch strobe).
- On each VBLANK rising edge it advances per-layer horizontal/vertical scroll offsets by a signed step and writes them out through a timed setup/strobe/hold bus cycle.
- Sits between TIMING and the tile generator layers. Replaces hand-driven latch sequences in benches and serves as the attract-mode scroll driver in the system build.

Parameters:
- LAYERS, 2, number of layer controllers, one latch strobe per layer (1..4).
- LATCH_PULSE, 2, number of CLK_6M cycles LATCH is held high (1..7).
- FRAME_LIMIT, 16, number of frames before DONE asserts and the block halts; 0 means run forever.
- H_INIT, 0, reset value of every horizontal offset (9 bits).
- V_INIT, 0, reset value of every vertical offset (8 bits).

Ports:
- CLK_6M  in  1  pixel clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  enables frame updates; sampled at VBLANK edge detect.
- VBLANK  in  1  vertical blank from TIMING, synchronous to CLK_6M.
- HSTEP  in  4*LAYERS  per-layer signed horizontal step; layer n at [4n+3:4n].
- VSTEP  in  4*LAYERS  per-layer signed vertical step, same packing.
- A  out  3  register address: 0 = H[7:0], 1 = {7'b0,H[8]}, 2 = V[7:0].
- D  out  8  register write data.
- LATCH  out  LAYERS  per-layer write strobe, active high, one-hot or zero.
- BUSY  out  1  high while a frame update is in progress.
- FRAME_CNT  out  16  completed frame updates; saturates at 16'hFFFF.
- OVERRUN  out  1  sticky; a VBLANK rising edge arrived while BUSY.
- DONE  out  1  sticky; FRAME_LIMIT reached.

Behaviour:
- Reset:
  - A=0, D=0, LATCH=0, BUSY=0, FRAME_CNT=0, OVERRUN=0, DONE=0.
  - All H offsets = H_INIT, all V offsets = V_INIT.
  - FSM = IDLE, VBLANK history register = 1, so a VBLANK already high at reset release is not an edge.
- Edge detect: an edge is VBLANK sampled 1 while the previous sample was 0.
- FSM states: IDLE, UPDATE, SETUP, STROBE, HOLD, NEXT, HALT.
- IDLE:
  - On edge with EN=1 and DONE=0, go to UPDATE and set BUSY=1 in the same edge.
  - On edge with EN=0, no action.
- UPDATE (1 cycle):
  - For every layer, H <= (H + sign-extended HSTEP) mod 512 and V <= (V + sign-extended VSTEP) mod 256.
  - Wrap is natural two's-complement: H=511 with step +1 gives 0; H=0 with step -1 gives 511.
  - Clear layer index and register index to 0; go to SETUP.
- SETUP (1 cycle): drive A and D for the current layer/register; LATCH=0.
- STROBE: LATCH[layer]=1 for exactly LATCH_PULSE cycles; A and D held stable.
- HOLD (1 cycle): LATCH=0; A and D still held.
- NEXT:
  - Increment register 0→1→2. After register 2, increment layer and return register to 0.
  - Return to SETUP while writes remain.
  - After the last layer's register 2: FRAME_CNT += 1 (saturating) and BUSY=0 in the same cycle.
  - If FRAME_LIMIT≠0 and the new FRAME_CNT equals FRAME_LIMIT, set DONE=1 and go to HALT; else go to IDLE.
- Write order per frame: layer 0 regs 0,1,2, then layer 1 regs 0,1,2, and so on.
- Frame update length: 1 + LAYERS*3*(LATCH_PULSE+3) cycles, counted from the edge-detect cycle to the BUSY fall, exclusive. Default = 1 + 2*3*5 = 31 cycles.
- D content is the offset value after the UPDATE step, never the pre-step value.
- Overrun: a VBLANK edge seen in any state other than IDLE or HALT sets OVERRUN. That edge is dropped, not queued.
- HALT: outputs idle (LATCH=0, BUSY=0), offsets frozen, edges ignored. Only reset leaves HALT.
- EN deassertion mid-update does not abort; the current frame completes.
- Asynchronous reset mid-update forces the reset values immediately, including LATCH=0 with no glitch pulse.
- At most one LATCH bit is high at any time.
- A and D change only in SETUP; they never change while any LATCH bit is high.

Test Plan:
- Reset with VBLANK high, release, hold VBLANK high -> no update, BUSY=0, LATCH=0, FRAME_CNT=0.
- LAYERS=2, HSTEP0=+1, VSTEP0=0, HSTEP1=-1, VSTEP1=+2, one VBLANK edge -> six writes in order: L0 (A0 D=01, A1 D=00, A2 D=00), then L1 (A0 D=FF, A1 D=01, A2 D=02). Each LATCH pulse is 2 cycles. BUSY falls 31 cycles after the edge. FRAME_CNT=1.
- H_INIT=511, HSTEP0=+1 -> L0 writes A0 D=00, A1 D=00. Then with HSTEP0=-1 on the next frame -> A0 D=FF, A1 D=01.
- Second VBLANK edge 10 cycles into an update -> OVERRUN=1, write sequence unaltered, FRAME_CNT advances by exactly 1.
- FRAME_LIMIT=16, 20 VBLANK edges spaced 100 cycles apart -> DONE=1 after the 16th update, FRAME_CNT=16, no LATCH activity on edges 17–20.
- Assert RST_N low during the STROBE of layer 1 reg 1 -> LATCH drops asynchronously, offsets return to H_INIT/V_INIT, and the next edge after release restarts from layer 0.

Source files
------------

// File: rtl/scroll_sequencer_if.sv
// Register-bus bundle from the scroll sequencer to the tilemap layer controllers.
// Address/data plus one latch strobe per layer.
interface scroll_sequencer_if #(
  parameter int LAYERS = 2
);
  logic [2:0]        A;
  logic [7:0]        D;
  logic [LAYERS-1:0] LATCH;

  modport master (
    output A,
    output D,
    output LATCH
  );

  modport slave (
    input A,
    input D,
    input LATCH
  );
endinterface

// File: rtl/scroll_sequencer.sv
// Per-frame scroll sequencer: steps each layer's H/V offsets on VBLANK rise
// and writes them out via setup/strobe/hold register bus cycles.
module scroll_sequencer #(
  parameter int         LAYERS      = 2,
  parameter int         LATCH_PULSE = 2,
  parameter int         FRAME_LIMIT = 16,
  parameter logic [8:0] H_INIT      = 9'd0,
  parameter logic [7:0] V_INIT      = 8'd0
) (
  input  logic                  CLK_6M,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  VBLANK,
  input  logic [4*LAYERS-1:0]   HSTEP,
  input  logic [4*LAYERS-1:0]   VSTEP,
  scroll_sequencer_if.master    bus,
  output logic                  BUSY,
  output logic [15:0]           FRAME_CNT,
  output logic                  OVERRUN,
  output logic                  DONE
);

  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    SETUP,
    STROBE,
    HOLD,
    NEXT,
    HALT
  } state_t;

  state_t      state;
  logic        vb_q;
  logic        vb_edge;
  logic [8:0]  h     [LAYERS];
  logic [7:0]  v     [LAYERS];
  logic [8:0]  h_new [LAYERS];
  logic [7:0]  v_new [LAYERS];
  logic [LW-1:0] lay;
  logic [LW-1:0] lay_n;
  logic [1:0]  rsel;
  logic [1:0]  rsel_n;
  logic [2:0]  pcnt;
  logic        last_w;
  logic [15:0] cnt_n;

  function automatic logic [7:0] reg_val(
    input logic [8:0] hv,
    input logic [7:0] vv,
    input logic [1:0] r
  );
    logic [7:0] res;
    res = vv;
    unique case (1'b1)
      (r == 2'd0): res = hv[7:0];
      (r == 2'd1): res = {7'b0, hv[8]};
      default:     res = vv;
    endcase
    return res;
  endfunction

  assign vb_edge = VBLANK & ~vb_q;

  // Sign-extended 4-bit steps; wrap comes from the truncating add.
  always_comb begin
    for (int i = 0; i < LAYERS; i++) begin
      h_new[i] = h[i] + {{5{HSTEP[4*i+3]}}, HSTEP[4*i +: 4]};
      v_new[i] = v[i] + {{4{VSTEP[4*i+3]}}, VSTEP[4*i +: 4]};
    end
  end

  assign last_w = (lay == LW'(LAYERS - 1)) && (rsel == 2'd2);
  assign lay_n  = (rsel == 2'd2) ? lay + 1'b1 : lay;
  assign rsel_n = (rsel == 2'd2) ? 2'd0 : rsel + 2'd1;
  assign cnt_n  = (FRAME_CNT == 16'hFFFF) ? FRAME_CNT
                                          : FRAME_CNT + 16'd1;

  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      vb_q      <= 1'b1;
      bus.A     <= 3'd0;
      bus.D     <= 8'd0;
      bus.LATCH <= '0;
      BUSY      <= 1'b0;
      FRAME_CNT <= 16'd0;
      OVERRUN   <= 1'b0;
      DONE      <= 1'b0;
      lay       <= '0;
      rsel      <= 2'd0;
      pcnt      <= 3'd0;
      for (int i = 0; i < LAYERS; i++) begin
        h[i] <= H_INIT;
        v[i] <= V_INIT;
      end
    end else begin
      vb_q <= VBLANK;
      // Edges during an update are dropped, only flagged.
      if (vb_edge && state != IDLE && state != HALT)
        OVERRUN <= 1'b1;
      unique case (state)
        IDLE: begin
          if (vb_edge && EN && !DONE) begin
            state <= UPDATE;
            BUSY  <= 1'b1;
          end
        end
        UPDATE: begin
          for (int i = 0; i < LAYERS; i++) begin
            h[i] <= h_new[i];
            v[i] <= v_new[i];
          end
          lay   <= '0;
          rsel  <= 2'd0;
          bus.A <= 3'd0;
          bus.D <= h_new[0][7:0];
          state <= SETUP;
        end
        SETUP: begin
          bus.LATCH <= LAYERS'(1) << lay;
          pcnt      <= 3'd0;
          state     <= STROBE;
        end
        STROBE: begin
          if (pcnt == 3'(LATCH_PULSE - 1)) begin
            bus.LATCH <= '0;
            state     <= HOLD;
          end else begin
            pcnt <= pcnt + 3'd1;
          end
        end
        HOLD: state <= NEXT;
        NEXT: begin
          if (last_w) begin
            BUSY      <= 1'b0;
            FRAME_CNT <= cnt_n;
            if (FRAME_LIMIT != 0 && cnt_n == 16'(FRAME_LIMIT)) begin
              DONE  <= 1'b1;
              state <= HALT;
            end else begin
              state <= IDLE;
            end
          end else begin
            lay   <= lay_n;
            rsel  <= rsel_n;
            bus.A <= {1'b0, rsel_n};
            bus.D <= reg_val(h[lay_n], v[lay_n], rsel_n);
            state <= SETUP;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
